animation_engine: RTL
=====================

// Module: animation_engine
// PURPOSE
//  Responder end of the animations_control command interface. Accepts step (process) and travel codes,
//  renders the matching graphic into the VGA adapter's pixel-write port (x, y, colour, plot), and returns
//  one-cycle done_step / done_travel pulses. Step draws a status box; travel slides a coin sprite one
//  pixel per frame. Sits between the transaction controllers and the VGA adapter.
// PARAMETERS
//  SPRITE_SIZE    4       coin sprite edge, pixels (square)
//  FRAME_TICKS    833333  clocks per animation frame (60 Hz at 50 MHz)
//  TRAVEL_PIXELS  40      pixels moved per travel command (1 px/frame)
//  BOX_SIZE       8       status box edge, pixels
// PORTS
//  clock        in   1  system clock (CLOCK_50)
//  resetn       in   1  asynchronous active-low reset
//  step         in   2  process code, 0 = none, 1..3 = draw status box k
//  travel       in   3  travel code, 0 = none, 1..7 = coin path k
//  done_step    out  1  one-cycle pulse: status box fully drawn
//  done_travel  out  1  one-cycle pulse: coin reached destination
//  busy         out  1  high from acceptance until the cycle of the done pulse
//  x            out  8  pixel column
//  y            out  7  pixel row
//  colour       out  3  RGB pixel colour
//  plot         out  1  write-enable to VGA adapter; x/y/colour valid when high
// BEHAVIOUR
//  - Reset (async, resetn=0): state IDLE; plot, done_step, done_travel, busy = 0; x, y, colour = 0;
//    all counters 0; both channels armed.
//  - Command acceptance (IDLE only): a channel is armed while its input has been seen at 0 since its
//    last done. Accept when input != 0 and channel armed; latch code; disarm that channel.
//    Travel has priority if both are acceptable in the same cycle; step stays pending, serviced next.
//  - The inputs are ignored while busy; a change of latched command mid-operation has no effect.
//  - States: IDLE, STEP_FILL, TRV_DRAW, TRV_WAIT, TRV_ERASE, DONE.
//  - STEP_FILL: first plot the cycle after acceptance; BOX_SIZE^2 consecutive plot cycles, raster order
//    (x fastest). Origin (8, 8 + 16*(k-1)); colour k=1 3'b010, k=2 3'b110, k=3 3'b100. -> DONE.
//  - Travel, position p = 0..TRAVEL_PIXELS-1, sprite origin (16*k + p, 60):
//    TRV_DRAW plots SPRITE_SIZE^2 pixels, colour 3'b110, raster order -> TRV_WAIT.
//    TRV_WAIT: plot=0 until frame tick; if p == TRAVEL_PIXELS-1 -> DONE, else -> TRV_ERASE.
//    TRV_ERASE plots the sprite at p in 3'b000, then p <= p+1 -> TRV_DRAW.
//    First draw at p=0 has no preceding erase; coin stays drawn at destination.
//  - DONE: one cycle; pulse done_step or done_travel per latched channel; busy=0 this cycle; -> IDLE.
//  - Frame tick: free-running counter 0..FRAME_TICKS-1, tick when == FRAME_TICKS-1, wraps to 0;
//    not reset by commands, so first TRV_WAIT lasts 0..FRAME_TICKS-1 cycles.
//  - Width: x = 16*k + p + col must stay < 160; y < 120. Parameters must respect this
//    (defaults: max x = 112 + 39 + 3 = 154). No saturation logic; out-of-range is a config error.
//  - Reset mid-operation aborts immediately; partially drawn pixels are left on screen. After release,
//    a still-held nonzero code is accepted again (channels re-armed by reset).
//  - Outputs x, y, colour, plot are registered (one cycle after the counter values that produce them).
// STRUCTURE
//  - Shared header controllers/animation_defs.vh: state encodings, colour constants (COL_BG, COL_COIN,
//    COL_STEP1..3), screen limits (160x120), travel base Y (60), and box/coin origin constants.
//  - One sub-module: frame_tick_gen (parameter FRAME_TICKS; ports clock, resetn, tick).
//  - Body: FSM + a shared pixel row/col counter pair used by fill, draw and erase.
// TESTING (bench overrides: FRAME_TICKS=4, TRAVEL_PIXELS=3, SPRITE_SIZE=2, BOX_SIZE=8)
//  1. step=2 held -> 64 plots, x 8..15, y 24..31, colour 110, raster order; single done_step;
//     no retrigger while held; step=0 for 1 cycle then 2 -> second identical fill.
//  2. travel=1 -> draw (16..17, 60..61) 110; wait tick; erase same in 000; draw at x 17..18;
//     ...; final draw at x 18..19; 20 plots total; done_travel one cycle after final tick.
//  3. step=1 and travel=3 asserted same cycle -> full travel sequence, done_travel, then box 1 fill,
//     done_step; busy high throughout except the done cycles.
//  4. resetn low during TRV_ERASE -> plot, busy, done_* 0 without a clock edge; release with travel=1
//     held -> restarts at p=0 (x 16).
//  5. TRV_WAIT check -> plot stays 0 between sprite draw end and next tick; gap never exceeds 4 cycles.

Source files
------------

// File: rtl/animation_engine_pkg.sv
// animation_engine_pkg
//   Shared definitions for the animation engine: FSM state encoding, colour
//   constants, screen limits and the fixed origins of the status boxes and the
//   coin travel row, plus small helpers that map a step code to its box.
package animation_engine_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_STEP_FILL,
    S_TRV_DRAW,
    S_TRV_WAIT,
    S_TRV_ERASE,
    S_DONE
  } state_t;

  localparam logic [2:0] COL_BG    = 3'b000;
  localparam logic [2:0] COL_COIN  = 3'b110;
  localparam logic [2:0] COL_STEP1 = 3'b010;
  localparam logic [2:0] COL_STEP2 = 3'b110;
  localparam logic [2:0] COL_STEP3 = 3'b100;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  localparam logic [7:0] BOX_ORIGIN_X  = 8'd8;
  localparam logic [6:0] BOX_ORIGIN_Y  = 7'd8;
  localparam logic [6:0] TRAVEL_BASE_Y = 7'd60;

  function automatic logic [2:0] step_colour(input logic [1:0] k);
    logic [2:0] c;
    case (k)
      2'd1:    c = COL_STEP1;
      2'd2:    c = COL_STEP2;
      2'd3:    c = COL_STEP3;
      default: c = COL_BG;
    endcase
    return c;
  endfunction

  // Box k sits at row 8 + 16*(k-1).
  function automatic logic [6:0] box_origin_y(input logic [1:0] k);
    logic [1:0] km1;
    km1 = k - 2'd1;
    return BOX_ORIGIN_Y + {1'b0, km1, 4'b0000};
  endfunction

endpackage

// File: rtl/animation_engine_if.sv
// animation_engine_if
//   Command/response and pixel-write bundle between the transaction
//   controllers (master), the animation engine (slave) and the VGA adapter.
//   step/travel      : command codes from the controller
//   done_step/travel : one-cycle completion pulses
//   busy             : engine occupied
//   x, y, colour     : pixel address and colour, valid while plot is high
interface animation_engine_if;
  logic [1:0] step;
  logic [2:0] travel;
  logic       done_step;
  logic       done_travel;
  logic       busy;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;

  modport master (
    output step, travel,
    input  done_step, done_travel, busy, x, y, colour, plot
  );

  modport slave (
    input  step, travel,
    output done_step, done_travel, busy, x, y, colour, plot
  );
endinterface

// File: rtl/animation_engine_frame_tick.sv
// frame_tick_gen
//   Free-running frame divider. Counts 0..FRAME_TICKS-1 and raises tick for
//   the single cycle the count equals FRAME_TICKS-1, then wraps to 0.
//   clock  : system clock
//   resetn : asynchronous active-low reset
//   tick   : one-cycle frame pulse
module frame_tick_gen #(
  parameter int FRAME_TICKS = 833333
) (
  input  logic clock,
  input  logic resetn,
  output logic tick
);
  localparam int CW = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
  localparam logic [CW-1:0] LAST = CW'(FRAME_TICKS - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) cnt <= '0;
    else if (tick) cnt <= '0;
    else cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/animation_engine.sv
// animation_engine
//   Responder end of the animation command interface. A step code k (1..3)
//   fills status box k; a travel code k (1..7) slides a coin sprite one pixel
//   per frame along row 60 starting at column 16*k. Pixels go out through the
//   x/y/colour/plot write port; completion is a one-cycle done pulse.
// Parameters
//   SPRITE_SIZE   coin edge in pixels
//   FRAME_TICKS   clocks per animation frame
//   TRAVEL_PIXELS pixels moved per travel command
//   BOX_SIZE      status box edge in pixels
// Ports
//   clock  : system clock
//   resetn : asynchronous active-low reset
//   bus    : slave side of animation_engine_if (commands in, done/busy and
//            registered pixel writes out)
module animation_engine
  import animation_engine_pkg::*;
#(
  parameter int SPRITE_SIZE   = 4,
  parameter int FRAME_TICKS   = 833333,
  parameter int TRAVEL_PIXELS = 40,
  parameter int BOX_SIZE      = 8
) (
  input  logic               clock,
  input  logic               resetn,
  animation_engine_if.slave  bus
);
  localparam logic [7:0] BOX_M1    = 8'(BOX_SIZE - 1);
  localparam logic [7:0] SPRITE_M1 = 8'(SPRITE_SIZE - 1);
  localparam logic [7:0] POS_LAST  = 8'(TRAVEL_PIXELS - 1);

  state_t     state, state_nx;
  logic [7:0] col, col_nx;
  logic [7:0] row, row_nx;
  logic [7:0] pos, pos_nx;
  logic [2:0] code, code_nx;
  logic       is_trv, is_trv_nx;
  logic       step_armed, step_armed_nx;
  logic       trv_armed, trv_armed_nx;
  logic       tick;

  logic       pix_plot;
  logic [7:0] pix_x;
  logic [6:0] pix_y;
  logic [2:0] pix_col;

  logic [7:0] edge_m1;
  logic       last_col, last_row;

  frame_tick_gen #(.FRAME_TICKS(FRAME_TICKS)) u_tick (
    .clock  (clock),
    .resetn (resetn),
    .tick   (tick)
  );

  // One row/col counter pair serves fill, draw and erase; only the edge
  // length differs between box and sprite.
  assign edge_m1  = (state == S_STEP_FILL) ? BOX_M1 : SPRITE_M1;
  assign last_col = (col == edge_m1);
  assign last_row = (row == edge_m1);

  always_comb begin
    state_nx      = state;
    col_nx        = col;
    row_nx        = row;
    pos_nx        = pos;
    code_nx       = code;
    is_trv_nx     = is_trv;
    // A channel re-arms whenever its input is seen at zero.
    step_armed_nx = step_armed | (bus.step == 2'd0);
    trv_armed_nx  = trv_armed | (bus.travel == 3'd0);
    pix_plot      = 1'b0;
    pix_x         = '0;
    pix_y         = '0;
    pix_col       = COL_BG;

    case (state)
      S_IDLE: begin
        col_nx = '0;
        row_nx = '0;
        pos_nx = '0;
        if (bus.travel != 3'd0 && trv_armed) begin
          is_trv_nx    = 1'b1;
          code_nx      = bus.travel;
          trv_armed_nx = 1'b0;
          state_nx     = S_TRV_DRAW;
        end else if (bus.step != 2'd0 && step_armed) begin
          is_trv_nx     = 1'b0;
          code_nx       = {1'b0, bus.step};
          step_armed_nx = 1'b0;
          state_nx      = S_STEP_FILL;
        end
      end

      S_STEP_FILL: begin
        pix_plot = 1'b1;
        pix_x    = BOX_ORIGIN_X + col;
        pix_y    = box_origin_y(code[1:0]) + row[6:0];
        pix_col  = step_colour(code[1:0]);
        if (last_col) begin
          col_nx = '0;
          row_nx = last_row ? 8'd0 : row + 8'd1;
          if (last_row) state_nx = S_DONE;
        end else begin
          col_nx = col + 8'd1;
        end
      end

      S_TRV_DRAW, S_TRV_ERASE: begin
        pix_plot = 1'b1;
        pix_x    = {1'b0, code, 4'b0000} + pos + col;
        pix_y    = TRAVEL_BASE_Y + row[6:0];
        pix_col  = (state == S_TRV_DRAW) ? COL_COIN : COL_BG;
        if (last_col) begin
          col_nx = '0;
          row_nx = last_row ? 8'd0 : row + 8'd1;
          if (last_row) begin
            if (state == S_TRV_DRAW) begin
              state_nx = S_TRV_WAIT;
            end else begin
              pos_nx   = pos + 8'd1;
              state_nx = S_TRV_DRAW;
            end
          end
        end else begin
          col_nx = col + 8'd1;
        end
      end

      S_TRV_WAIT: begin
        if (tick) state_nx = (pos == POS_LAST) ? S_DONE : S_TRV_ERASE;
      end

      S_DONE: state_nx = S_IDLE;

      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state      <= S_IDLE;
      col        <= '0;
      row        <= '0;
      pos        <= '0;
      code       <= '0;
      is_trv     <= 1'b0;
      step_armed <= 1'b1;
      trv_armed  <= 1'b1;
    end else begin
      state      <= state_nx;
      col        <= col_nx;
      row        <= row_nx;
      pos        <= pos_nx;
      code       <= code_nx;
      is_trv     <= is_trv_nx;
      step_armed <= step_armed_nx;
      trv_armed  <= trv_armed_nx;
    end
  end

  // Pixel port is registered: it shows the pixel addressed by last cycle's
  // counters, so the final pixel of a fill lands in the DONE cycle.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      bus.plot   <= 1'b0;
      bus.x      <= '0;
      bus.y      <= '0;
      bus.colour <= '0;
    end else begin
      bus.plot   <= pix_plot;
      bus.x      <= pix_x;
      bus.y      <= pix_y;
      bus.colour <= pix_col;
    end
  end

  assign bus.busy        = (state != S_IDLE) && (state != S_DONE);
  assign bus.done_step   = (state == S_DONE) && !is_trv;
  assign bus.done_travel = (state == S_DONE) && is_trv;

endmodule
